// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Multiply is shift-add on operand magnitudes; divide is restoring shift-subtract.
// Sign correction is applied only when the final result is registered.
// Optional macro ALU_MULDIV_FASTPATH_EN: trivial requests (zero operands,
// divide-by-zero, signed overflow) skip CALC and go straight to DONE. The result
// is then presented right after the accepting edge.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_result;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;      // product accumulator / partial remainder
    logic [WIDTH-1:0] r_lo;      // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] r_b_mag;   // multiplicand / divisor magnitude
    logic             r_neg_q;   // negate product or quotient
    logic             r_neg_r;   // negate remainder (dividend sign)
    logic             r_div0;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    // Request decode: operand signedness, magnitudes and special cases
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_res;

    assign w_a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign w_b_signed = op[2] ? ~op[0] : ~op[1];
    assign w_a_neg    = w_a_signed & a[WIDTH-1];
    assign w_b_neg    = w_b_signed & b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag    = w_b_neg ? (~b + WIDTH'(1)) : b;
    assign w_div0     = (b == '0);
    assign w_ovf      = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);

`ifdef ALU_MULDIV_FASTPATH_EN
    // Requests whose result is known without iterating
    always_comb begin
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (!op[2]) begin
            w_fast = (a == '0) | (b == '0);
        end else if (w_div0) begin
            w_fast     = 1'b1;
            w_fast_res = op[1] ? a : '1;
        end else if (w_ovf) begin
            w_fast     = 1'b1;
            w_fast_res = op[1] ? '0 : MIN_NEG;
        end else begin
            w_fast = (a == '0);
        end
    end
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // One radix-2 step of the selected operation
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b_mag};
    // A zero divisor always "fits", which leaves the dividend as remainder
    assign w_ge     = ~w_diff[WIDTH] | r_div0;

    // Next accumulator contents for multiply or divide
    always_comb begin
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_op[2]) begin
            w_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    // Sign correction and special-case override of the final step
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_final;

    always_comb begin
        w_prod  = {w_hi_nxt, w_lo_nxt};
        if (r_neg_q) begin
            w_prod = ~w_prod + PW'(1);
        end
        w_quo   = r_neg_q ? (~w_lo_nxt + WIDTH'(1)) : w_lo_nxt;
        w_rem   = r_neg_r ? (~w_hi_nxt + WIDTH'(1)) : w_hi_nxt;
        w_final = '0;
        if (!r_op[2]) begin
            w_final = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];
        end else if (r_div0) begin
            w_final = r_op[1] ? w_rem : '1;
        end else if (r_ovf) begin
            w_final = r_op[1] ? '0 : MIN_NEG;
        end else begin
            w_final = r_op[1] ? w_rem : w_quo;
        end
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b_mag  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_op    <= op;
                r_hi    <= '0;
                r_lo    <= w_a_mag;
                r_b_mag <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_div0  <= w_div0;
                r_ovf   <= w_ovf;
                r_cnt   <= CNT_LOAD;
                if (w_fast) begin
                    r_result <= w_fast_res;
                end
            end
        end else if (r_state == S_CALC) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CNT_LAST) begin
                r_result <= w_final;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq (WIDTH=32): directed RV32M cases, handshake/backpressure,
// async reset abort, and randomized operations against a 64-bit arithmetic model.
module tb_alu_muldiv_seq;

    localparam int unsigned W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from acceptance edge to out_valid for a given request
    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        if (!op[2]) special = (a == 0) || (b == 0);
        else        special = (b == 0) || (a == 0) || (a == MINV && b == 32'hFFFF_FFFF && !op[0]);
`ifdef ALU_MULDIV_FASTPATH_EN
        return special ? 0 : int'(W);
`else
        return special ? int'(W) : int'(W);
`endif
    endfunction

    // Present one request and wait (bounded) for out_valid
    task automatic issue_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int lat, output bit rdy_low, output bit busy_hi);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i = $urandom; b_i = $urandom;
        lat = 0; rdy_low = 1'b1; busy_hi = 1'b1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            if (busy !== 1'b1) busy_hi = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/idle_ready"}, 64'(in_ready), 64'(1));
        check({tag, "/idle_valid"}, 64'(out_valid), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit rdy_low;
        bit busy_hi;
        issue_wait(op, a, b, lat, rdy_low, busy_hi);
        check({tag, "/result"}, 64'(result), 64'(exp));
        check({tag, "/latency"}, 64'(lat), 64'(exp_latency(op, a, b)));
        check({tag, "/ready_low"}, 64'(rdy_low), 64'(1));
        check({tag, "/busy"}, 64'(busy_hi), 64'(1));
        consume(tag);
    endtask

    initial begin
        int          lat;
        bit          rdy_low;
        bit          busy_hi;
        bit          stable;
        bit          saw_valid;
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        #1;
        check("reset/in_ready", 64'(in_ready), 64'(1));
        check("reset/out_valid", 64'(out_valid), 64'(0));
        check("reset/busy", 64'(busy), 64'(0));
        check("reset/result", 64'(result), 64'(0));
        #20;
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_neg",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min",  3'd1, MINV,          MINV,          32'h4000_0000);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("divu",      3'd5, 32'd100,       32'd7,         32'd14);
        run_op("remu",      3'd7, 32'd100,       32'd7,         32'd2);
        run_op("divu_zero", 3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF);
        run_op("rem_zero",  3'd6, 32'h1234,      32'd0,         32'h1234);
        run_op("div_zero_n",3'd4, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FFFF);
        run_op("rem_zero_n",3'd6, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00);
        run_op("div_ovf",   3'd4, MINV,          32'hFFFF_FFFF, MINV);
        run_op("rem_ovf",   3'd6, MINV,          32'hFFFF_FFFF, 32'h0);
        run_op("mul_zero",  3'd0, 32'd0,         32'h1234_5678, 32'h0);
        run_op("div_a0",    3'd4, 32'd0,         32'd5,         32'h0);

        // Backpressure: result held while the consumer stalls
        issue_wait(3'd0, 32'd1234, 32'd5678, lat, rdy_low, busy_hi);
        check("bp/first_result", 64'(result), 64'(32'd7006652));
        held = result;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        check("bp/stable", 64'(stable), 64'(1));
        consume("bp");
        check("bp/busy_clear", 64'(busy), 64'(0));

        // Asynchronous reset five cycles into a divide
        @(negedge clk);
        op_i = 3'd4; a_i = 32'd1000; b_i = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst/in_ready", 64'(in_ready), 64'(1));
        check("arst/out_valid", 64'(out_valid), 64'(0));
        check("arst/busy", 64'(busy), 64'(0));
        check("arst/result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("arst/no_output", 64'(saw_valid), 64'(0));
        run_op("post_rst_mul", 3'd0, 32'd3, 32'd5, 32'd15);

        // Randomized operations, biased toward the corner cases
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h0;
                2: begin ra = MINV; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 15));
                4: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
